// File: rtl/idwt_pkg.sv
// idwt_pkg: shared constants, coefficients and sample type for the db2 reconstruction FIR
// Contents: TAPS, default widths, Q2.14 synthesis filters H0/H1, sample_t.
package idwt_pkg;
  localparam int TAPS = 4;
  localparam int DATA_W_DEF = 16;
  localparam int FRAC_DEF = 14;
  localparam int ACC_W_DEF = 36;
  localparam int COEF_W = 16;
  typedef logic signed [DATA_W_DEF-1:0] sample_t;
  localparam logic signed [COEF_W-1:0] H0 [TAPS] = '{16'sd7913, 16'sd13705, 16'sd3672, -16'sd2120};
  localparam logic signed [COEF_W-1:0] H1 [TAPS] = '{-16'sd2120, -16'sd3672, 16'sd13705, -16'sd7913};
endpackage

// File: rtl/idwt_tap_line.sv
// idwt_tap_line: N-deep shift register with shift enable and synchronous clear
// Ports: clk, reset (async, active high), shift_i (advance one place), clr_i (zero all taps),
//        d_i (new sample), taps_o (taps_o[0] newest .. taps_o[N-1] oldest).
module idwt_tap_line #(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                shift_i,
  input  logic                clr_i,
  input  logic [W-1:0]        d_i,
  output logic [N-1:0][W-1:0] taps_o
);
  logic [N-1:0][W-1:0] taps_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) taps_q <= '0;
    else if (clr_i) taps_q <= '0;
    else if (shift_i) taps_q <= {taps_q[N-2:0], d_i};
  assign taps_o = taps_q;
endmodule

// File: rtl/idwt_recon_fir.sv
// idwt_recon_fir: db2 inverse-DWT reconstruction FIR summing filtered approximation and detail streams
// Ports: clk, reset (async, active high), clk_enable (global stall), in_valid, g_in, f_in (upsampled
//        approximation/detail samples), flush (sync clear), y_out, out_valid, ovf (result out of range).
// Build option: define IDWT_RECON_SAT_EN to clamp out-of-range results instead of wrapping.
// Pipeline: delay lines shift on accept, then products, adder-tree sum, rounded output (3 enabled cycles).
module idwt_recon_fir
  import idwt_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] g_in,
  input  logic signed [DATA_W-1:0] f_in,
  input  logic                     flush,
  output logic signed [DATA_W-1:0] y_out,
  output logic                     out_valid,
  output logic                     ovf
);
  localparam int PW = 2 * DATA_W;
  localparam int NP = 2 * TAPS;
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] MAXV = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
  logic accept, clr;
  logic [TAPS-1:0][DATA_W-1:0] g_tap, f_tap;
  logic signed [PW-1:0] prod_d [NP];
  logic signed [PW-1:0] prod_q [NP];
  logic signed [ACC_W-1:0] sum_d, sum_q, rnd;
  logic signed [DATA_W-1:0] y_d, y_q;
  logic [2:0] fill_d, fill_q;
  logic ovf_d, ovf_q, v_tap_q, v_prod_q, v_sum_q, out_valid_q;
  // flush beats a simultaneous sample
  assign accept = clk_enable & in_valid & ~flush;
  assign clr    = clk_enable & flush;
  idwt_tap_line #(.W(DATA_W), .N(TAPS)) u_g_line (
    .clk(clk), .reset(reset), .shift_i(accept), .clr_i(clr), .d_i(g_in), .taps_o(g_tap)
  );
  idwt_tap_line #(.W(DATA_W), .N(TAPS)) u_f_line (
    .clk(clk), .reset(reset), .shift_i(accept), .clr_i(clr), .d_i(f_in), .taps_o(f_tap)
  );
  for (genvar i = 0; i < TAPS; i++) begin : g_prod
    assign prod_d[i]        = PW'($signed(g_tap[i])) * PW'(H0[i]);
    assign prod_d[TAPS + i] = PW'($signed(f_tap[i])) * PW'(H1[i]);
  end
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NP; i++) sum_d = sum_d + ACC_W'(prod_q[i]);
    rnd = (sum_q + HALF) >>> FRAC;
    ovf_d = (rnd > MAXV) || (rnd < MINV);
`ifdef IDWT_RECON_SAT_EN
    y_d = ovf_d ? (rnd[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}}) : rnd[DATA_W-1:0];
`else
    y_d = rnd[DATA_W-1:0];
`endif
    fill_d = clr ? 3'd0 : accept ? fill_q + 3'(fill_q != 3'd4) : fill_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < NP; i++) prod_q[i] <= '0;
      sum_q       <= '0;
      y_q         <= '0;
      fill_q      <= '0;
      ovf_q       <= 1'b0;
      v_tap_q     <= 1'b0;
      v_prod_q    <= 1'b0;
      v_sum_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clk_enable) begin
      for (int i = 0; i < NP; i++) prod_q[i] <= prod_d[i];
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      // a result exists once the 4th sample since reset/flush has entered the taps
      v_tap_q     <= accept && (fill_q >= 3'd3);
      v_prod_q    <= v_tap_q & ~flush;
      v_sum_q     <= v_prod_q & ~flush;
      out_valid_q <= v_sum_q & ~flush;
      ovf_q       <= v_sum_q & ~flush & ovf_d;
      // y_out only moves on a delivered result, so a flush leaves the last value visible
      if (v_sum_q && !flush) y_q <= y_d;
    end
  assign y_out     = y_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_idwt_recon_fir.sv
// tb_idwt_recon_fir: randomized and directed bench for idwt_recon_fir against an arithmetic reference model
module tb_idwt_recon_fir;
  import idwt_pkg::*;
  typedef struct {
    longint y;
    bit     ov;
    int     due;
  } exp_t;
  logic clk = 0, reset = 1, clk_enable = 0, in_valid = 0, flush = 0;
  sample_t g_in = '0, f_in = '0;
  logic signed [15:0] y_out;
  logic out_valid, ovf;
  int checks = 0, errors = 0, ecyc = 0, nacc = 0;
  exp_t q[$];
  longint gh[$], fh[$], ylog[$], a_log[$];
  bit exp_ov, last_ov = 0;
  longint last_y = 0;
  int imp[7] = '{0, 0, 0, 16384, 0, 0, 0};
  int want[4] = '{7913, 13705, 3672, -2120};
  longint gs[12], fs[12];

  always #5 clk = ~clk;

  idwt_recon_fir dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .in_valid(in_valid),
    .g_in(g_in), .f_in(f_in), .flush(flush),
    .y_out(y_out), .out_valid(out_valid), .ovf(ovf)
  );

  task automatic check(string tag, longint obs, longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(int due);
    longint s = 0, r;
    logic [63:0] t;
    exp_t e;
    for (int k = 0; k < 4; k++) s += gh[k] * H0[k] + fh[k] * H1[k];
    r = (s + 8192) >>> 14;
    e.ov = (r > 32767) || (r < -32768);
`ifdef IDWT_RECON_SAT_EN
    e.y = e.ov ? (r < 0 ? -32768 : 32767) : r;
`else
    t = r;
    e.y = $signed(t[15:0]);
`endif
    e.due = due;
    return e;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      if (clk_enable) begin
        ecyc++;
        if (flush) begin
          gh.delete(); fh.delete(); q.delete(); nacc = 0;
        end else if (in_valid) begin
          gh.push_front(g_in); fh.push_front(f_in);
          if (gh.size() > 4) begin void'(gh.pop_back()); void'(fh.pop_back()); end
          nacc++;
          if (nacc >= 4) q.push_back(model(ecyc + 3));
        end
        #1;
        exp_ov = q.size() > 0 && q[0].due == ecyc;
        check("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
          check("y_out", y_out, q[0].y);
          check("ovf", ovf, q[0].ov);
          ylog.push_back(y_out);
          void'(q.pop_front());
        end
      end else begin
        #1;
        check("hold_valid", out_valid, last_ov);
        check("hold_y", y_out, last_y);
      end
      last_ov = out_valid;
      last_y  = y_out;
    end
  end

  task automatic drive(bit en, bit v, longint g, longint f, bit fl);
    @(negedge clk);
    clk_enable = en; in_valid = v; g_in = sample_t'(g); f_in = sample_t'(f); flush = fl;
  endtask

  task automatic feed(longint g, longint f);
    drive(1, 1, g, f, 0);
  endtask

  task automatic idle(int n);
    repeat (n) drive(1, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1;
    #1;
    check("rst_y", y_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ovf", ovf, 0);
    gh.delete(); fh.delete(); q.delete(); nacc = 0; last_y = 0; last_ov = 0;
    clk_enable = 0; in_valid = 0; flush = 0;
    @(negedge clk);
    #2 reset = 0;
  endtask

  task automatic impulse();
    ylog.delete();
    foreach (imp[i]) feed(imp[i], 0);
    idle(5);
    check("imp_count", ylog.size(), 4);
    for (int i = 0; i < 4; i++) if (i < ylog.size()) check("imp_y", ylog[i], want[i]);
  endtask

  function automatic longint rnd_sample();
    return ($urandom % 4 == 0) ? longint'($urandom_range(0, 65535)) - 32768
                               : longint'($urandom_range(0, 16000)) - 8000;
  endfunction

  initial begin
    do_reset();
    impulse();
    // DC gain: 1000 * 23170 / 16384 rounds to 1414
    drive(1, 0, 0, 0, 1);
    ylog.delete();
    repeat (10) feed(1000, 0);
    idle(4);
    check("dc_count", ylog.size(), 7);
    if (ylog.size() > 0) check("dc_y", ylog[$], 1414);
    drive(1, 0, 0, 0, 1);
    ylog.delete();
    repeat (8) feed(32767, 0);
    idle(4);
`ifdef IDWT_RECON_SAT_EN
    if (ylog.size() > 0) check("big_y", ylog[$], 32767);
`else
    if (ylog.size() > 0) check("big_y", ylog[$], -19197);
`endif
    // stalled run must reproduce the uninterrupted run
    foreach (gs[i]) begin gs[i] = rnd_sample(); fs[i] = rnd_sample(); end
    drive(1, 0, 0, 0, 1);
    ylog.delete();
    foreach (gs[i]) feed(gs[i], fs[i]);
    idle(4);
    a_log = ylog;
    drive(1, 0, 0, 0, 1);
    ylog.delete();
    for (int i = 0; i < 6; i++) feed(gs[i], fs[i]);
    repeat (5) drive(0, $urandom % 2, rnd_sample(), rnd_sample(), $urandom % 2);
    for (int i = 6; i < 12; i++) feed(gs[i], fs[i]);
    idle(4);
    check("stall_count", ylog.size(), a_log.size());
    foreach (a_log[i]) if (i < ylog.size()) check("stall_y", ylog[i], a_log[i]);
    // flush with in_valid mid-stream
    drive(1, 0, 0, 0, 1);
    ylog.delete();
    repeat (8) feed(rnd_sample(), rnd_sample());
    drive(1, 1, 1234, 4321, 1);
    idle(4);
    check("flush_pre", ylog.size(), 2);
    repeat (3) feed(rnd_sample(), rnd_sample());
    idle(4);
    check("flush_3", ylog.size(), 2);
    feed(rnd_sample(), rnd_sample());
    idle(4);
    check("flush_4", ylog.size(), 3);
    // random traffic with gaps, stalls and occasional flushes
    repeat (400)
      drive($urandom % 8 != 0, $urandom % 4 != 0, rnd_sample(), rnd_sample(), $urandom % 50 == 0);
    idle(4);
    // reset between accepted samples, then the impulse reruns identically
    drive(1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) feed(imp[i], 0);
    do_reset();
    impulse();
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/idwt_recon_fir.md
IDWT_RECON_FIR -- requirements
Module: idwt_recon_fir

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the sample width of g_in, f_in and y_out.
REQ-002 Parameter FRAC, default 14, SHALL set the fractional bits of the coefficients (Q2.14).
REQ-003 Parameter ACC_W, default 36, SHALL set the accumulator width.
REQ-004 clk  in  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-005 reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-006 clk_enable  in  1  SHALL advance all state only when high; when low, all state SHALL hold.
REQ-007 in_valid  in  1  SHALL qualify g_in/f_in; a sample is accepted when in_valid & clk_enable.
REQ-008 g_in  in  DATA_W signed  SHALL carry the upsampled approximation stream.
REQ-009 f_in  in  DATA_W signed  SHALL carry the upsampled detail stream.
REQ-010 flush  in  1  SHALL synchronously clear the delay lines, fill count and pipeline valids (qualified by clk_enable).
REQ-011 y_out  out  DATA_W signed  SHALL carry the reconstructed sample.
REQ-012 out_valid  out  1  SHALL mark y_out valid for one enabled cycle per result.
REQ-013 ovf  out  1  SHALL pulse with out_valid when the result exceeded the DATA_W signed range.

Function
REQ-014 The block SHALL compute y[n] = round((sum k=0..3 of H0[k]*g[n-k] + H1[k]*f[n-k]) / 2^FRAC).
REQ-015 H0 SHALL be {7913, 13705, 3672, -2120}, and H1 SHALL be {-2120, -3672, 13705, -7913}, as Q2.14 db2 reconstruction values.
REQ-016 Rounding SHALL add 2^(FRAC-1) and then arithmetic-shift right by FRAC (round half up).
REQ-017 Products SHALL be full-precision 2*DATA_W bits, sign-extended to ACC_W before summation; no intermediate truncation.
REQ-018 The pipeline SHALL be: stage 1 registers the 8 products, stage 2 registers the adder-tree sum, and stage 3 registers the rounded/limited y_out, out_valid and ovf.
REQ-019 Latency SHALL be exactly 3 enabled cycles from the accepting edge to out_valid high.
REQ-020 Each delay line SHALL shift by one position only on an accepted sample.
REQ-021 A 3-bit fill counter SHALL count accepted samples, saturating at 4.
REQ-022 Results SHALL be marked valid only when the fill count is 3 or more at the accepting edge, so that the 4th and later samples produce outputs.
REQ-023 When clk_enable is low, the pipeline, counters and outputs SHALL freeze, including holding out_valid.
REQ-024 When flush and in_valid are both high, flush SHALL win and the sample SHALL be discarded.
REQ-025 On flush, in-flight results SHALL be dropped (valids cleared) and y_out SHALL hold its last value.
REQ-026 Gaps in in_valid SHALL NOT insert zeros; sample index advances only on acceptance.

Reset
REQ-027 On reset, y_out, out_valid, ovf, both delay lines, all pipeline registers and the fill counter SHALL become 0 immediately.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight results; the first output after release SHALL require 4 new samples.

Configuration
REQ-029 With IDWT_RECON_SAT_EN defined, an out-of-range result SHALL clamp to +32767 or -32768 and set ovf.
REQ-030 Without IDWT_RECON_SAT_EN, y_out SHALL be the low DATA_W bits (two's-complement wrap), and ovf SHALL still flag the overflow.

Structure
REQ-031 Package idwt_pkg SHALL hold TAPS=4, the H0/H1 coefficient arrays, DATA_W/FRAC/ACC_W defaults and the signed sample typedef.
REQ-032 Sub-module idwt_tap_line (a TAPS-deep signed shift register with shift-enable and synchronous clear) SHALL be instantiated twice, once for g and once for f.

Verification
REQ-033 After reset, inject g = 0,0,0,16384,0,0,0 with f = 0 -> y_out SHALL be 7913, 13705, 3672, -2120, each 3 cycles after its sample.
REQ-034 Feed g = 1000 and f = 0 continuously -> the first valid is on sample 4, and steady y_out SHALL be 1414.
REQ-035 Feed g = 32767 and f = 0 continuously -> with SAT_EN, y_out = 32767 and ovf = 1; without it, y_out = -19197 and ovf = 1.
REQ-036 Toggle clk_enable low for 5 cycles mid-stream -> outputs SHALL be identical to the uninterrupted run, merely delayed 5 cycles.
REQ-037 Assert flush together with in_valid mid-stream -> that sample SHALL be dropped, no out_valid SHALL appear until 4 new samples are accepted, and in-flight results SHALL be suppressed.
REQ-038 Assert reset between two accepted samples -> all outputs SHALL be 0 asynchronously, and the REQ-033 sequence SHALL rerun identically.
